// File: rtl/duel_match_ctrl.sv
// duel_match_ctrl: N-player match sequencer for the factorisation quiz game.
// Sequences rounds, requests questions and arbitrates the first correct
// answer. It applies damage to the losers, tracks per-player HP and
// declares either a winner or a draw.
module duel_match_ctrl #(
  parameter int                N_PL    = 2,
  parameter int                HP_W    = 4,
  parameter int                HP_INIT = 7,
  parameter int                DMG     = 1,
  parameter int                TMO_W   = 24,
  parameter logic [TMO_W-1:0]  TMO_CYC = 24'd10_000_000
) (
  input  logic                   CLK,
  input  logic                   RST,        // asynchronous, active low
  input  logic                   START,
  input  logic [N_PL-1:0]        READY,
  input  logic [N_PL-1:0]        RES_VALID,
  input  logic [N_PL-1:0]        RES_OK,
  output logic                   Q_REQ,
  output logic                   ROUND_ACT,
  output logic [2:0]             STATE,
  output logic [N_PL*HP_W-1:0]   HP,
  output logic [N_PL-1:0]        ALIVE,
  output logic [N_PL-1:0]        LOCKOUT,
  output logic [N_PL-1:0]        ROUND_WIN,
  output logic [7:0]             ROUND_CNT,
  output logic [N_PL-1:0]        WINNER,
  output logic                   DRAW
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_QREQ  = 3'd2,
    S_ANS   = 3'd3,
    S_JUDGE = 3'd4,
    S_CHECK = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  // DMG and HP_INIT are expected to fit in HP_W bits.
  localparam logic [HP_W-1:0]      HP_INIT_V = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]      DMG_V     = HP_W'(DMG);
  localparam logic [N_PL*HP_W-1:0] HP_RST    = {N_PL{HP_INIT_V}};
  localparam logic [TMO_W-1:0]     TMO_ONE   = TMO_W'(1);
  localparam logic [N_PL-1:0]      PL_ONE    = N_PL'(1);

  state_t                state_q, state_d;
  logic [N_PL*HP_W-1:0]  hp_q, hp_d;
  logic [N_PL-1:0]       lock_q, lock_d;
  logic [N_PL-1:0]       rwin_q, rwin_d;
  logic [N_PL-1:0]       winner_q, winner_d;
  logic [7:0]            rcnt_q, rcnt_d;
  logic                  draw_q, draw_d;
  logic                  q_req_q, q_req_d;
  logic                  act_q, act_d;
  logic [TMO_W-1:0]      timer_q, timer_d;

  logic [N_PL-1:0]       alive;
  logic [3:0]            alive_cnt;
  logic [N_PL-1:0]       cand_ok, cand_bad, cand_ok_m1, lock_new;

  // A player is alive while its HP register is non-zero.
  for (genvar gi = 0; gi < N_PL; gi++) begin : g_alive
    assign alive[gi] = |hp_q[gi*HP_W +: HP_W];
  end

  // Number of live players, used to decide the match outcome.
  always_comb begin
    alive_cnt = 4'd0;
    for (int i = 0; i < N_PL; i++) begin
      alive_cnt = alive_cnt + 4'(alive[i]);
    end
  end

  // Answer candidates this cycle; dead or locked players are masked out.
  always_comb begin
    cand_ok    = RES_VALID & RES_OK & alive & ~lock_q;
    cand_bad   = RES_VALID & ~RES_OK & alive & ~lock_q;
    cand_ok_m1 = cand_ok - PL_ONE;
    lock_new   = lock_q | cand_bad;
  end

  // Next-state and next-output logic of the match FSM.
  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    lock_d   = lock_q;
    rwin_d   = rwin_q;
    winner_d = winner_q;
    rcnt_d   = rcnt_q;
    draw_d   = draw_q;
    timer_d  = timer_q;

    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_WAIT;
      end

      S_WAIT: begin
        // Dead players never hold up the next round.
        if (&(READY | ~alive)) begin
          state_d = S_QREQ;
          lock_d  = '0;
          rwin_d  = '0;
          timer_d = TMO_CYC;
        end
      end

      S_QREQ: begin
        state_d = S_ANS;
      end

      S_ANS: begin
        if (cand_ok != '0) begin
          // A correct answer beats a timeout in the same cycle; a
          // simultaneous correct answer from several players draws the round.
          rwin_d  = ((cand_ok & cand_ok_m1) == '0) ? cand_ok : '0;
          state_d = S_JUDGE;
        end else begin
          lock_d = lock_new;
          if (&(lock_new | ~alive)) begin
            rwin_d  = '0;
            state_d = S_JUDGE;
          end else if (TMO_CYC != '0) begin
            timer_d = timer_q - TMO_ONE;
            if (timer_q <= TMO_ONE) begin
              rwin_d  = '0;
              state_d = S_JUDGE;
            end
          end
        end
      end

      S_JUDGE: begin
        if (rwin_q != '0) begin
          for (int j = 0; j < N_PL; j++) begin
            if (alive[j] && !rwin_q[j]) begin
              hp_d[j*HP_W +: HP_W] = (hp_q[j*HP_W +: HP_W] > DMG_V) ?
                                     hp_q[j*HP_W +: HP_W] - DMG_V : '0;
            end
          end
        end
        if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (alive_cnt == 4'd0) begin
          draw_d  = 1'b1;
          state_d = S_OVER;
        end else if (alive_cnt == 4'd1) begin
          winner_d = alive;
          state_d  = S_OVER;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_OVER: begin
        if (START) begin
          hp_d     = HP_RST;
          rcnt_d   = 8'd0;
          winner_d = '0;
          draw_d   = 1'b0;
          lock_d   = '0;
          rwin_d   = '0;
          state_d  = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Strobes registered so they line up with the state they belong to.
    q_req_d = (state_d == S_QREQ);
    act_d   = (state_d == S_ANS);
  end

  // State and output registers; reset aborts any match in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      hp_q     <= HP_RST;
      lock_q   <= '0;
      rwin_q   <= '0;
      winner_q <= '0;
      rcnt_q   <= 8'd0;
      draw_q   <= 1'b0;
      q_req_q  <= 1'b0;
      act_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      lock_q   <= lock_d;
      rwin_q   <= rwin_d;
      winner_q <= winner_d;
      rcnt_q   <= rcnt_d;
      draw_q   <= draw_d;
      q_req_q  <= q_req_d;
      act_q    <= act_d;
      timer_q  <= timer_d;
    end
  end

  assign STATE     = state_q;
  assign HP        = hp_q;
  assign ALIVE     = alive;
  assign LOCKOUT   = lock_q;
  assign ROUND_WIN = rwin_q;
  assign WINNER    = winner_q;
  assign ROUND_CNT = rcnt_q;
  assign DRAW      = draw_q;
  assign Q_REQ     = q_req_q;
  assign ROUND_ACT = act_q;

endmodule

// File: tb/tb_duel_match_ctrl.sv
// Directed bench for duel_match_ctrl using three instances:
//   A: 2 players, HP 7, timeout 16 cycles
//   B: 2 players, HP 2, timeout disabled
//   C: 3 players, HP 2, timeout 16 cycles
module tb_duel_match_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, start_c;
  logic [2:0]  ready, rv, ok;

  logic        a_qreq, a_act, a_draw;
  logic [2:0]  a_state;
  logic [7:0]  a_hp, a_rcnt;
  logic [1:0]  a_alive, a_lock, a_rwin, a_win;

  logic        b_qreq, b_act, b_draw;
  logic [2:0]  b_state;
  logic [7:0]  b_hp, b_rcnt;
  logic [1:0]  b_alive, b_lock, b_rwin, b_win;

  logic        c_qreq, c_act, c_draw;
  logic [2:0]  c_state;
  logic [11:0] c_hp;
  logic [7:0]  c_rcnt;
  logic [2:0]  c_alive, c_lock, c_rwin, c_win;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  duel_match_ctrl #(.N_PL(2), .HP_W(4), .HP_INIT(7), .DMG(1), .TMO_W(24), .TMO_CYC(24'd16)) dut_a (
    .CLK(clk), .RST(rst_n), .START(start_a), .READY(ready[1:0]), .RES_VALID(rv[1:0]),
    .RES_OK(ok[1:0]), .Q_REQ(a_qreq), .ROUND_ACT(a_act), .STATE(a_state), .HP(a_hp),
    .ALIVE(a_alive), .LOCKOUT(a_lock), .ROUND_WIN(a_rwin), .ROUND_CNT(a_rcnt),
    .WINNER(a_win), .DRAW(a_draw));

  duel_match_ctrl #(.N_PL(2), .HP_W(4), .HP_INIT(2), .DMG(1), .TMO_W(24), .TMO_CYC(24'd0)) dut_b (
    .CLK(clk), .RST(rst_n), .START(start_b), .READY(ready[1:0]), .RES_VALID(rv[1:0]),
    .RES_OK(ok[1:0]), .Q_REQ(b_qreq), .ROUND_ACT(b_act), .STATE(b_state), .HP(b_hp),
    .ALIVE(b_alive), .LOCKOUT(b_lock), .ROUND_WIN(b_rwin), .ROUND_CNT(b_rcnt),
    .WINNER(b_win), .DRAW(b_draw));

  duel_match_ctrl #(.N_PL(3), .HP_W(4), .HP_INIT(2), .DMG(1), .TMO_W(24), .TMO_CYC(24'd16)) dut_c (
    .CLK(clk), .RST(rst_n), .START(start_c), .READY(ready), .RES_VALID(rv),
    .RES_OK(ok), .Q_REQ(c_qreq), .ROUND_ACT(c_act), .STATE(c_state), .HP(c_hp),
    .ALIVE(c_alive), .LOCKOUT(c_lock), .ROUND_WIN(c_rwin), .ROUND_CNT(c_rcnt),
    .WINNER(c_win), .DRAW(c_draw));

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ready = 3'b000; rv = 3'b000; ok = 3'b000;
    repeat (3) tick();
    chk("rst_hold_state", 32'(a_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset defaults (A)
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_hp", 32'(a_hp), 32'h77);
    chk("rst_alive", 32'(a_alive), 32'h3);
    chk("rst_lock", 32'(a_lock), 32'h0);
    chk("rst_rwin", 32'(a_rwin), 32'h0);
    chk("rst_winner", 32'(a_win), 32'h0);
    chk("rst_draw", 32'(a_draw), 32'h0);
    chk("rst_rcnt", 32'(a_rcnt), 32'h0);
    chk("rst_qreq", 32'(a_qreq), 32'h0);
    chk("rst_act", 32'(a_act), 32'h0);
    $display("txn reset: state=%0d hp=%h alive=%b", a_state, a_hp, a_alive);

    // Basic round (A): P0 wins
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("basic_wait", 32'(a_state), 32'd1);
    ready = 3'b011; tick();
    chk("basic_qreq_st", 32'(a_state), 32'd2);
    chk("basic_qreq_hi", 32'(a_qreq), 32'd1);
    tick();
    chk("basic_qreq_lo", 32'(a_qreq), 32'd0);
    chk("basic_act", 32'(a_act), 32'd1);
    chk("basic_ans", 32'(a_state), 32'd3);
    rv = 3'b001; ok = 3'b001; tick(); rv = 3'b000; ok = 3'b000;
    chk("basic_judge", 32'(a_state), 32'd4);
    chk("basic_rwin", 32'(a_rwin), 32'h1);
    tick(); tick();
    chk("basic_back", 32'(a_state), 32'd1);
    chk("basic_hp", 32'(a_hp), 32'h67);
    chk("basic_rcnt", 32'(a_rcnt), 32'd1);
    $display("txn basic_round: rwin=%b hp=%h rcnt=%0d", a_rwin, a_hp, a_rcnt);

    // Wrong answer locks P0; its later correct strobe is ignored (A)
    tick();
    chk("wrong_qreq_clr", 32'(a_rwin), 32'h0);
    tick();
    rv = 3'b001; ok = 3'b000; tick();
    chk("wrong_lock", 32'(a_lock), 32'h1);
    chk("wrong_stay", 32'(a_state), 32'd3);
    rv = 3'b001; ok = 3'b001; tick();
    chk("locked_ignored", 32'(a_state), 32'd3);
    rv = 3'b010; ok = 3'b010; tick(); rv = 3'b000; ok = 3'b000;
    chk("wrong_p1_win", 32'(a_rwin), 32'h2);
    tick(); tick();
    chk("wrong_hp", 32'(a_hp), 32'h66);
    $display("txn wrong_answer: lock=%b rwin=%b hp=%h", a_lock, a_rwin, a_hp);

    // Tie: both correct in the same cycle (A)
    tick(); tick();
    chk("tie_lock_clr", 32'(a_lock), 32'h0);
    rv = 3'b011; ok = 3'b011; tick(); rv = 3'b000; ok = 3'b000;
    chk("tie_judge", 32'(a_state), 32'd4);
    chk("tie_rwin", 32'(a_rwin), 32'h0);
    tick(); tick();
    chk("tie_hp", 32'(a_hp), 32'h66);
    chk("tie_rcnt", 32'(a_rcnt), 32'd3);
    $display("txn tie: rwin=%b hp=%h rcnt=%0d", a_rwin, a_hp, a_rcnt);

    // Timeout after exactly 16 ANSWER cycles (A)
    tick(); tick();
    repeat (15) tick();
    chk("tmo_not_yet", 32'(a_state), 32'd3);
    tick();
    chk("tmo_judge", 32'(a_state), 32'd4);
    chk("tmo_rwin", 32'(a_rwin), 32'h0);
    tick(); tick();
    chk("tmo_hp", 32'(a_hp), 32'h66);
    chk("tmo_rcnt", 32'(a_rcnt), 32'd4);
    $display("txn timeout: hp=%h rcnt=%0d", a_hp, a_rcnt);

    // Correct answer on the timeout cycle wins (A)
    tick(); tick();
    repeat (15) tick();
    rv = 3'b010; ok = 3'b010; tick(); rv = 3'b000; ok = 3'b000;
    chk("tmo_ans_judge", 32'(a_state), 32'd4);
    chk("tmo_ans_rwin", 32'(a_rwin), 32'h2);
    tick(); tick();
    chk("tmo_ans_hp", 32'(a_hp), 32'h65);
    chk("tmo_ans_rcnt", 32'(a_rcnt), 32'd5);
    $display("txn timeout_answer: rwin=%b hp=%h", a_rwin, a_hp);

    // Match end (B): P0 wins two rounds; no timeout with TMO_CYC=0
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("b_wait", 32'(b_state), 32'd1);
    tick(); tick();
    rv = 3'b001; ok = 3'b001; tick(); rv = 3'b000; ok = 3'b000;
    tick(); tick();
    chk("b_r1_hp", 32'(b_hp), 32'h12);
    tick(); tick();
    repeat (20) tick();
    chk("b_no_tmo", 32'(b_state), 32'd3);
    rv = 3'b001; ok = 3'b001; tick(); rv = 3'b000; ok = 3'b000;
    tick(); tick();
    chk("b_over", 32'(b_state), 32'd6);
    chk("b_winner", 32'(b_win), 32'h1);
    chk("b_hp_end", 32'(b_hp), 32'h02);
    chk("b_alive", 32'(b_alive), 32'h1);
    chk("b_draw", 32'(b_draw), 32'h0);
    tick(); tick();
    chk("b_hold", 32'(b_state), 32'd6);
    $display("txn match_end: winner=%b hp=%h rcnt=%0d", b_win, b_hp, b_rcnt);
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("b_restart_st", 32'(b_state), 32'd1);
    chk("b_restart_hp", 32'(b_hp), 32'h22);
    chk("b_restart_rcnt", 32'(b_rcnt), 32'd0);
    chk("b_restart_win", 32'(b_win), 32'h0);
    $display("txn restart: state=%0d hp=%h", b_state, b_hp);

    // Three players (C): kill P2, then play with it dead
    ready = 3'b111;
    start_c = 1'b1; tick(); start_c = 1'b0;
    tick(); tick();
    rv = 3'b001; ok = 3'b001; tick(); rv = 3'b000; ok = 3'b000;
    tick(); tick();
    chk("c_r1_hp", 32'(c_hp), 32'h112);
    tick(); tick();
    rv = 3'b010; ok = 3'b010; tick(); rv = 3'b000; ok = 3'b000;
    tick(); tick();
    chk("c_r2_hp", 32'(c_hp), 32'h011);
    chk("c_r2_alive", 32'(c_alive), 32'h3);
    chk("c_r2_state", 32'(c_state), 32'd1);
    $display("txn p2_dead: hp=%h alive=%b", c_hp, c_alive);
    ready = 3'b011; tick();
    chk("c_dead_rdy", 32'(c_state), 32'd2);
    tick();
    rv = 3'b100; ok = 3'b100; tick();
    chk("c_dead_ignored", 32'(c_state), 32'd3);
    rv = 3'b011; ok = 3'b000; tick(); rv = 3'b000; ok = 3'b000;
    chk("c_alllock_st", 32'(c_state), 32'd4);
    chk("c_alllock_lock", 32'(c_lock), 32'h3);
    chk("c_alllock_rwin", 32'(c_rwin), 32'h0);
    tick(); tick();
    chk("c_draw_hp", 32'(c_hp), 32'h011);
    chk("c_draw_rcnt", 32'(c_rcnt), 32'd3);
    $display("txn all_locked: lock=%b hp=%h rcnt=%0d", c_lock, c_hp, c_rcnt);

    // Reset in the middle of ANSWER (C)
    tick(); tick();
    chk("c_mid_ans", 32'(c_state), 32'd3);
    rst_n = 1'b0; #1;
    chk("c_rst_state", 32'(c_state), 32'd0);
    chk("c_rst_hp", 32'(c_hp), 32'h222);
    chk("c_rst_alive", 32'(c_alive), 32'h7);
    chk("c_rst_act", 32'(c_act), 32'h0);
    tick(); rst_n = 1'b1; tick();
    chk("c_rst_rcnt", 32'(c_rcnt), 32'd0);
    chk("c_rst_idle", 32'(c_state), 32'd0);
    $display("txn mid_reset: state=%0d hp=%h", c_state, c_hp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
